// File: rtl/add_sub_logic_unit.sv
// -----------------------------------------------------------------------------
// add_sub_logic_unit
//   Execute-stage ALU. Selects one of four operations on two WIDTH-bit
//   operands. It gives a zero-latency combinational result and a registered,
//   valid-qualified copy with status flags.
//
//   op = 0 : a + b          carry = carry out of the MSB
//   op = 1 : a - b          carry = borrow (a < b, unsigned)
//   op = 2 : ~b             a ignored, carry = 0
//   op = 3 : a > b unsigned result is 1 or 0, zero-extended, carry = 0
//
// Ports
//   clk       in   rising-edge clock for every registered output
//   rst       in   asynchronous active-high reset
//   op        in   operation select (2 bits)
//   a, b      in   operands (WIDTH bits)
//   in_valid  in   op/a/b are valid; the result is captured on the next edge
//   r         out  combinational result
//   r_q       out  registered result
//   out_valid out  r_q and the flags hold a fresh capture
//   carry_q   out  registered carry/borrow flag
//   ovf_q     out  registered signed-overflow flag
//   zero_q    out  registered result-is-zero flag
//
// Configuration macro: ADD_SUB_LOGIC_FLAGS_EN
//   defined     -> carry/ovf/zero are computed and registered
//   not defined -> carry_q/ovf_q/zero_q are tied to 0 (ports remain present)
// -----------------------------------------------------------------------------
module add_sub_logic_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_q,
  output logic             out_valid,
  output logic             carry_q,
  output logic             ovf_q,
  output logic             zero_q
);

  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_q_r;
  logic             out_valid_r;

  // Result select for the four operations.
  always_comb begin
    r_s = '0;
    case (op)
      2'd0:    r_s = a + b;
      2'd1:    r_s = a - b;
      2'd2:    r_s = ~b;
      2'd3:    r_s = {{(WIDTH-1){1'b0}}, (a > b)};
      default: r_s = '0;
    endcase
  end

  assign r = r_s;

  // Result and valid capture; a cycle without in_valid only drops out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_r       <= '0;
      out_valid_r <= 1'b0;
    end else if (in_valid) begin
      r_q_r       <= r_s;
      out_valid_r <= 1'b1;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign r_q       = r_q_r;
  assign out_valid = out_valid_r;

`ifdef ADD_SUB_LOGIC_FLAGS_EN
  // Signed overflow from the operand and result sign bits. Subtract overflows
  // when the operand signs differ and the result sign leaves a's sign.
  function automatic logic ovf_calc(input logic [1:0] op_i,
                                    input logic       sa,
                                    input logic       sb,
                                    input logic       sr);
    logic v;
    case (op_i)
      2'd0:    v = (sa == sb) && (sr != sa);
      2'd1:    v = (sa != sb) && (sr != sa);
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  logic [WIDTH:0] sum_ext_s;
  logic           carry_s;
  logic           ovf_s;
  logic           zero_s;
  logic           carry_r;
  logic           ovf_r;
  logic           zero_r;

  // Flag computation from the operands and the selected result.
  always_comb begin
    sum_ext_s = {1'b0, a} + {1'b0, b};
    carry_s   = 1'b0;
    case (op)
      2'd0:    carry_s = sum_ext_s[WIDTH];
      2'd1:    carry_s = (a < b);
      default: carry_s = 1'b0;
    endcase
    ovf_s  = ovf_calc(op, a[WIDTH-1], b[WIDTH-1], r_s[WIDTH-1]);
    zero_s = (r_s == '0);
  end

  // Flag capture alongside r_q; the flags hold while in_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
    end else if (in_valid) begin
      carry_r <= carry_s;
      ovf_r   <= ovf_s;
      zero_r  <= zero_s;
    end else begin
      carry_r <= carry_r;
      ovf_r   <= ovf_r;
      zero_r  <= zero_r;
    end
  end

  assign carry_q = carry_r;
  assign ovf_q   = ovf_r;
  assign zero_q  = zero_r;
`else
  assign carry_q = 1'b0;
  assign ovf_q   = 1'b0;
  assign zero_q  = 1'b0;
`endif

endmodule

// File: tb/tb_add_sub_logic_unit.sv
// -----------------------------------------------------------------------------
// tb_add_sub_logic_unit
//   Self-checking bench for add_sub_logic_unit. It runs directed vectors,
//   pipeline/hold steps, asynchronous reset, and a randomized run. Expected
//   values come from an integer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_add_sub_logic_unit;

  localparam int W   = 16;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_valid = 1'b0;
  logic [W-1:0] r;
  logic [W-1:0] r_q;
  logic         out_valid;
  logic         carry_q;
  logic         ovf_q;
  logic         zero_q;

  int errors = 0;
  int checks = 0;

  // Expected registered state
  int unsigned e_rq = 0;
  bit e_c = 1'b0, e_v = 1'b0, e_z = 1'b0;

  add_sub_logic_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .op(op), .a(a), .b(b), .in_valid(in_valid),
    .r(r), .r_q(r_q), .out_valid(out_valid),
    .carry_q(carry_q), .ovf_q(ovf_q), .zero_q(zero_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on unsigned and signed values.
  function automatic void ref_model(input int o, input int unsigned ua, input int unsigned ub,
                                    output int unsigned rr, output bit c, output bit v, output bit z);
    int sa, sb, s;
    sa = (ua >= MOD/2) ? int'(ua) - MOD : int'(ua);
    sb = (ub >= MOD/2) ? int'(ub) - MOD : int'(ub);
    c = 1'b0; v = 1'b0;
    case (o)
      0: begin
        rr = (ua + ub) % MOD;
        c  = (ua + ub) >= MOD;
        s  = sa + sb;
        v  = (s > MOD/2 - 1) || (s < -(MOD/2));
      end
      1: begin
        rr = (ua + MOD - ub) % MOD;
        c  = ua < ub;
        s  = sa - sb;
        v  = (s > MOD/2 - 1) || (s < -(MOD/2));
      end
      2: rr = (MOD - 1) - ub;
      default: rr = (ua > ub) ? 1 : 0;
    endcase
    z = (rr == 0);
  endfunction

  task automatic check_reg(input string tag);
    check({tag, ".r_q"}, {16'd0, r_q}, e_rq);
`ifdef ADD_SUB_LOGIC_FLAGS_EN
    check({tag, ".carry_q"}, {31'd0, carry_q}, {31'd0, e_c});
    check({tag, ".ovf_q"},   {31'd0, ovf_q},   {31'd0, e_v});
    check({tag, ".zero_q"},  {31'd0, zero_q},  {31'd0, e_z});
`else
    check({tag, ".carry_q"}, {31'd0, carry_q}, 32'd0);
    check({tag, ".ovf_q"},   {31'd0, ovf_q},   32'd0);
    check({tag, ".zero_q"},  {31'd0, zero_q},  32'd0);
`endif
  endtask

  // Drive one cycle. Check the combinational result, then the registered outputs after the edge.
  task automatic step(input string tag, input int o, input int unsigned ua, input int unsigned ub, input bit vld);
    int unsigned rr; bit c, v, z;
    @(negedge clk);
    op = o[1:0]; a = ua[W-1:0]; b = ub[W-1:0]; in_valid = vld;
    ref_model(o, ua, ub, rr, c, v, z);
    #1;
    check({tag, ".r"}, {16'd0, r}, rr);
    @(posedge clk);
    #1;
    if (vld && !rst) begin
      e_rq = rr; e_c = c; e_v = v; e_z = z;
    end
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, vld && !rst});
    check_reg(tag);
  endtask

  initial begin
    // Reset state
    #2;
    check("reset.out_valid", {31'd0, out_valid}, 32'd0);
    check_reg("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    step("add_2_3",      0, 2, 3, 1'b1);
    step("add_100_200",  0, 100, 200, 1'b1);
    step("add_wrap",     0, 16'hFFFF, 1, 1'b1);
    step("add_ovf",      0, 16'h7FFF, 1, 1'b1);
    step("sub_10_5",     1, 10, 5, 1'b1);
    step("sub_borrow",   1, 100, 200, 1'b1);
    step("sub_ovf",      1, 16'h8000, 1, 1'b1);
    step("sub_zero",     1, 1234, 1234, 1'b1);
    step("not_7_11",     2, 7, 11, 1'b1);
    step("not_11_7",     2, 11, 7, 1'b1);
    step("not_ffff",     2, 5, 16'hFFFF, 1'b1);
    step("gt_3_10",      3, 3, 10, 1'b1);
    step("gt_10_3",      3, 10, 3, 1'b1);
    step("gt_eq",        3, 9, 9, 1'b1);

    // Pipeline: capture, then hold while in_valid is low
    step("pipe_cap",     0, 2, 3, 1'b1);
    step("pipe_hold",    1, 40, 50, 1'b0);
    step("pipe_hold2",   3, 7, 1, 1'b0);

    // Asynchronous reset between edges while out_valid=1
    step("pre_rst",      0, 16'hFFFF, 1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    e_rq = 0; e_c = 1'b0; e_v = 1'b0; e_z = 1'b0;
    check("async_rst.out_valid", {31'd0, out_valid}, 32'd0);
    check_reg("async_rst");
    // An operation issued during reset is dropped
    step("drop_in_rst",  0, 2, 3, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    step("post_rst",     1, 16'h8000, 1, 1'b1);

    // Randomized run
    for (int i = 0; i < 300; i++) begin
      step("rand", int'($urandom_range(3, 0)), $urandom_range(MOD - 1, 0),
           $urandom_range(MOD - 1, 0), ($urandom_range(3, 0) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
